// File: rtl/imem_access_ctrl.sv
// Arbitrates the single combinational-read instruction memory between the fetch stage and
// the program loader, with 1-cycle registered responses and an exclusive loader lock.
module imem_access_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_valid,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rsp_instr,
    input  logic                  ld_req_valid,
    input  logic                  ld_req_we,
    input  logic [ADDR_WIDTH-1:0] ld_req_addr,
    input  logic [DATA_WIDTH-1:0] ld_req_wdata,
    output logic                  ld_req_ready,
    output logic                  ld_rsp_valid,
    output logic [DATA_WIDTH-1:0] ld_rsp_rdata,
    input  logic                  ld_lock,
    output logic                  core_hold,
    output logic [ADDR_WIDTH:0]   ld_wr_count,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {SHARED, DRAIN, LOCKED} state_t;
    typedef enum logic {GNT_IF, GNT_LD} grant_t;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

    state_t state;
    state_t next_state;
    grant_t last_grant;
    logic   grant_if;
    logic   grant_ld;

    // Ready means "would be granted if valid"; ties go to whoever was not granted last.
    always_comb begin
        if_req_ready = 1'b0;
        ld_req_ready = 1'b0;
        case (state)
            SHARED: begin
                if_req_ready = !(ld_req_valid && !ld_req_we && last_grant == GNT_IF);
                ld_req_ready = !ld_req_we && !(if_req_valid && last_grant == GNT_LD);
            end
            DRAIN:   ld_req_ready = !ld_req_we;
            LOCKED:  ld_req_ready = 1'b1;
            default: ;
        endcase
    end

    assign grant_if = if_req_valid && if_req_ready;
    assign grant_ld = ld_req_valid && ld_req_ready;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (grant_if) begin
            mem_addr = if_req_addr;
        end else if (grant_ld) begin
            mem_addr  = ld_req_addr;
            mem_we    = ld_req_we;
            mem_wdata = ld_req_we ? ld_req_wdata : '0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            SHARED:  if (ld_lock) next_state = DRAIN;
            DRAIN:   next_state = LOCKED;
            LOCKED:  if (!ld_lock) next_state = SHARED;
            default: next_state = SHARED;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= SHARED;
            last_grant   <= GNT_LD;
            core_hold    <= 1'b0;
            if_rsp_valid <= 1'b0;
            if_rsp_instr <= '0;
            ld_rsp_valid <= 1'b0;
            ld_rsp_rdata <= '0;
            ld_wr_count  <= '0;
        end else begin
            state     <= next_state;
            core_hold <= (next_state != SHARED);

            if (state == LOCKED && !ld_lock) begin
                last_grant <= GNT_LD;
            end else if (grant_if) begin
                last_grant <= GNT_IF;
            end else if (grant_ld) begin
                last_grant <= GNT_LD;
            end

            if_rsp_valid <= grant_if;
            if (grant_if) begin
                if_rsp_instr <= mem_rdata;
            end

            ld_rsp_valid <= grant_ld;
            if (grant_ld) begin
                ld_rsp_rdata <= ld_req_we ? '0 : mem_rdata;
            end

            // Count survives unlock; only the next DRAIN clears it.
            if (state == DRAIN) begin
                ld_wr_count <= '0;
            end else if (state == LOCKED && grant_ld && ld_req_we && ld_wr_count != '1) begin
                ld_wr_count <= ld_wr_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed bench for imem_access_ctrl: arbitration, lock sequence, reset and count saturation.
module tb_imem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid;
    logic [15:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_instr;
    logic        ld_req_valid;
    logic        ld_req_we;
    logic [15:0] ld_req_addr;
    logic [31:0] ld_req_wdata;
    logic        ld_req_ready;
    logic        ld_rsp_valid;
    logic [31:0] ld_rsp_rdata;
    logic        ld_lock;
    logic        core_hold;
    logic [16:0] ld_wr_count;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Small instance used only for counter saturation.
    logic        s_rst_n;
    logic        s_if_req_valid;
    logic [1:0]  s_if_req_addr;
    logic        s_if_req_ready;
    logic        s_if_rsp_valid;
    logic [31:0] s_if_rsp_instr;
    logic        s_ld_req_valid;
    logic        s_ld_req_we;
    logic [1:0]  s_ld_req_addr;
    logic [31:0] s_ld_req_wdata;
    logic        s_ld_req_ready;
    logic        s_ld_rsp_valid;
    logic [31:0] s_ld_rsp_rdata;
    logic        s_ld_lock;
    logic        s_core_hold;
    logic [2:0]  s_ld_wr_count;
    logic [1:0]  s_mem_addr;
    logic        s_mem_we;
    logic [31:0] s_mem_wdata;
    logic [31:0] s_mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imem_access_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_instr(if_rsp_instr),
        .ld_req_valid(ld_req_valid), .ld_req_we(ld_req_we), .ld_req_addr(ld_req_addr),
        .ld_req_wdata(ld_req_wdata), .ld_req_ready(ld_req_ready),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_rdata(ld_rsp_rdata),
        .ld_lock(ld_lock), .core_hold(core_hold), .ld_wr_count(ld_wr_count),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    imem_access_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) dut_small (
        .clk(clk), .rst_n(s_rst_n),
        .if_req_valid(s_if_req_valid), .if_req_addr(s_if_req_addr), .if_req_ready(s_if_req_ready),
        .if_rsp_valid(s_if_rsp_valid), .if_rsp_instr(s_if_rsp_instr),
        .ld_req_valid(s_ld_req_valid), .ld_req_we(s_ld_req_we), .ld_req_addr(s_ld_req_addr),
        .ld_req_wdata(s_ld_req_wdata), .ld_req_ready(s_ld_req_ready),
        .ld_rsp_valid(s_ld_rsp_valid), .ld_rsp_rdata(s_ld_rsp_rdata),
        .ld_lock(s_ld_lock), .core_hold(s_core_hold), .ld_wr_count(s_ld_wr_count),
        .mem_addr(s_mem_addr), .mem_we(s_mem_we), .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata)
    );

    // Memory model: unwritten words read a fixed per-address pattern.
    logic [31:0] mem [0:65535];
    bit          written [0:65535];

    function automatic logic [31:0] init_word(input logic [15:0] a);
        return (a == 16'h0010) ? 32'h0000_0013 : {16'hC0DE, a};
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    always_comb mem_rdata = written[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
    assign s_mem_rdata = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0;
        if_req_addr  = '0;
        ld_req_valid = 1'b0;
        ld_req_we    = 1'b0;
        ld_req_addr  = '0;
        ld_req_wdata = '0;
        ld_lock      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        s_rst_n        = 1'b0;
        s_if_req_valid = 1'b0;
        s_if_req_addr  = '0;
        s_ld_req_valid = 1'b0;
        s_ld_req_we    = 1'b0;
        s_ld_req_addr  = '0;
        s_ld_req_wdata = 32'h5555_AAAA;
        s_ld_lock      = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_if_rsp_valid", if_rsp_valid, 0);
        check("rst_ld_rsp_valid", ld_rsp_valid, 0);
        check("rst_core_hold", core_hold, 0);
        check("rst_if_rsp_instr", if_rsp_instr, 0);
        check("rst_ld_rsp_rdata", ld_rsp_rdata, 0);
        check("rst_ld_wr_count", ld_wr_count, 0);
        rst_n = 1'b1;

        // Fetch only
        @(negedge clk);
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0010;
        #1;
        check("fetch_ready", if_req_ready, 1);
        check("fetch_mem_addr", mem_addr, 16'h0010);
        check("fetch_mem_we", mem_we, 0);
        @(negedge clk);
        if_req_valid = 1'b0;
        #1;
        check("fetch_rsp_valid", if_rsp_valid, 1);
        check("fetch_rsp_instr", if_rsp_instr, 32'h0000_0013);
        check("fetch_no_ld_rsp", ld_rsp_valid, 0);
        @(negedge clk);
        #1;
        check("fetch_rsp_pulse", if_rsp_valid, 0);

        // Contention: fetch wins first after reset, then strict alternation
        do_reset();
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0001;
        ld_req_valid = 1'b1;
        ld_req_addr  = 16'h0002;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                if_req_valid = 1'b0;
                ld_req_valid = 1'b0;
            end
            #1;
            if (k < 4) begin
                check("arb_if_ready", if_req_ready, (k % 2 == 0));
                check("arb_ld_ready", ld_req_ready, (k % 2 == 1));
                check("arb_mem_addr", mem_addr, (k % 2 == 0) ? 16'h0001 : 16'h0002);
            end
            if (k > 0) begin
                check("arb_if_rsp_valid", if_rsp_valid, (k % 2 == 1));
                check("arb_ld_rsp_valid", ld_rsp_valid, (k % 2 == 0));
                if (k % 2 == 1) check("arb_if_rsp_instr", if_rsp_instr, 32'hC0DE_0001);
                else            check("arb_ld_rsp_rdata", ld_rsp_rdata, 32'hC0DE_0002);
            end
            @(negedge clk);
        end

        // Loader write blocked while shared; fetch keeps flowing
        ld_req_valid = 1'b1;
        ld_req_we    = 1'b1;
        ld_req_addr  = 16'h0005;
        ld_req_wdata = 32'h1111_2222;
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0010;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("blk_ld_ready", ld_req_ready, 0);
            check("blk_mem_we", mem_we, 0);
            check("blk_if_ready", if_req_ready, 1);
            if (k > 0) check("blk_if_rsp", {if_rsp_valid, if_rsp_instr}, {1'b1, 32'h0000_0013});
            @(negedge clk);
        end
        ld_req_valid = 1'b0;
        ld_req_we    = 1'b0;

        // Lock requested in the same cycle as a fetch grant
        ld_lock = 1'b1;
        #1;
        check("lock_fetch_ready", if_req_ready, 1);
        @(negedge clk);
        ld_req_valid = 1'b1;
        ld_req_we    = 1'b1;
        ld_req_addr  = 16'h0000;
        ld_req_wdata = 32'hDEAD_BEEF;
        #1;
        check("drain_core_hold", core_hold, 1);
        check("drain_if_rsp_valid", if_rsp_valid, 1);
        check("drain_if_rsp_instr", if_rsp_instr, 32'h0000_0013);
        check("drain_if_ready", if_req_ready, 0);
        check("drain_ld_wr_ready", ld_req_ready, 0);
        check("drain_mem_we", mem_we, 0);
        @(negedge clk);
        if_req_valid = 1'b0;
        #1;
        check("lk_ld_ready", ld_req_ready, 1);
        check("lk_mem_we", mem_we, 1);
        check("lk_mem_addr", mem_addr, 16'h0000);
        check("lk_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("lk_count_clear", ld_wr_count, 0);
        for (int a = 1; a < 4; a++) begin
            @(negedge clk);
            ld_req_addr = 16'(a);
            #1;
            check("lk_mem_we", mem_we, 1);
            check("lk_mem_addr", mem_addr, 16'(a));
            check("lk_ld_rsp", {ld_rsp_valid, ld_rsp_rdata}, {1'b1, 32'h0});
        end
        @(negedge clk);
        ld_req_valid = 1'b0;
        ld_req_we    = 1'b0;
        ld_lock      = 1'b0;
        #1;
        check("lk_last_rsp", {ld_rsp_valid, ld_rsp_rdata}, {1'b1, 32'h0});
        check("lk_wr_count", ld_wr_count, 4);
        check("lk_core_hold", core_hold, 1);
        check("lk_idle_mem_we", mem_we, 0);
        @(negedge clk);
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0002;
        #1;
        check("unlk_core_hold", core_hold, 0);
        check("unlk_if_ready", if_req_ready, 1);
        check("unlk_ld_rsp_valid", ld_rsp_valid, 0);
        @(negedge clk);
        if_req_valid = 1'b0;
        #1;
        check("unlk_fetch", {if_rsp_valid, if_rsp_instr}, {1'b1, 32'hDEAD_BEEF});
        check("unlk_count_held", ld_wr_count, 4);

        // Reset while a loader read response is in flight
        @(negedge clk);
        ld_lock = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ld_req_valid = 1'b1;
        ld_req_we    = 1'b1;
        ld_req_addr  = 16'h0008;
        ld_req_wdata = 32'h1234_5678;
        #1;
        check("rmid_wr_ready", ld_req_ready, 1);
        @(negedge clk);
        ld_req_we   = 1'b0;
        ld_req_addr = 16'h0001;
        #1;
        check("rmid_rd_ready", ld_req_ready, 1);
        check("rmid_rd_mem_we", mem_we, 0);
        @(negedge clk);
        rst_n        = 1'b0;
        ld_req_valid = 1'b0;
        ld_lock      = 1'b0;
        #1;
        check("rmid_pre_rsp", {ld_rsp_valid, ld_rsp_rdata}, {1'b1, 32'hDEAD_BEEF});
        check("rmid_pre_count", ld_wr_count, 1);
        @(negedge clk);
        rst_n        = 1'b1;
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0010;
        #1;
        check("rmid_ld_rsp_valid", ld_rsp_valid, 0);
        check("rmid_core_hold", core_hold, 0);
        check("rmid_count", ld_wr_count, 0);
        check("rmid_shared_if_ready", if_req_ready, 1);
        @(negedge clk);
        if_req_valid = 1'b0;

        // Counter saturation with ADDR_WIDTH = 2 (limit 7)
        s_rst_n   = 1'b1;
        s_ld_lock = 1'b1;
        @(negedge clk);
        @(negedge clk);
        s_ld_req_valid = 1'b1;
        s_ld_req_we    = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            s_ld_req_addr = 2'(k);
            @(negedge clk);
            #1;
            check("sat_count", s_ld_wr_count, (k < 7) ? k : 7);
        end
        s_ld_req_valid = 1'b0;
        s_ld_lock      = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
